// File: rtl/reload_pkg.sv
// rtl/reload_pkg.sv - shared state type and default sizes for the reload scheduler
package reload_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/reload_if.sv
// rtl/reload_if.sv - reload request handshake plus downstream counter load/count signals
interface reload_if
  import reload_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             enable;
  logic             req_valid;
  logic [WIDTH-1:0] req_data;
  logic             req_ready;
  logic [WIDTH-1:0] count;
  logic             load;
  logic [WIDTH-1:0] data;

  modport master (
    output enable, req_valid, req_data, count,
    input  req_ready, load, data
  );

  modport slave (
    input  enable, req_valid, req_data, count,
    output req_ready, load, data
  );

endinterface

// File: rtl/reload_fifo.sv
// rtl/reload_fifo.sv - reload value queue; head reads zero when empty, no bypass path
module reload_fifo
  import reload_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Offers while full and pops while empty are silently ignored.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reload_scheduler.sv
// rtl/reload_scheduler.sv - feeds queued reload values to a down counter exactly when it hits zero
module reload_scheduler
  import reload_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  reload_if.slave                bus,
  output logic                   expired,
  output logic                   underflow,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             full;
  logic             empty;
  logic             cnt_zero;
  logic [WIDTH-1:0] head;

  reload_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.req_valid),
    .push_data (bus.req_data),
    .pop       (load),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign cnt_zero      = (bus.count == '0);
  assign bus.req_ready = ~full;
  assign bus.load      = load;
  assign bus.data      = head;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      expired   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      expired   <= (state != IDLE) && cnt_zero;
      underflow <= (state == RUN) && cnt_zero && bus.enable && empty;
    end
  end

  // Reload lands in the same cycle count is zero, so the counter never wraps while running.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        load = bus.enable & ~empty;
        if (load) state_nxt = RUN;
      end
      RUN: begin
        if (cnt_zero) begin
          load      = bus.enable & ~empty;
          state_nxt = load ? RUN : IDLE;
        end else if (!bus.enable) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_zero) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reload_scheduler.sv
// tb/tb_reload_scheduler.sv - directed bench pairing the scheduler with a loadable down counter
module tb_reload_scheduler;
  import reload_pkg::*;

  logic       clk;
  logic       rst;
  logic       expired;
  logic       underflow;
  logic       busy;
  logic [2:0] level;

  int errors = 0;
  int checks = 0;

  reload_if #(.WIDTH(4)) bus ();

  reload_scheduler #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .expired   (expired),
    .underflow (underflow),
    .busy      (busy),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream loadable down counter; free-running decrement, wraps if never reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bus.count <= 4'd0;
    else if (bus.load) bus.count <= bus.data;
    else               bus.count <= bus.count - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_load(input int bound);
    int n;
    n = 0;
    while (!bus.load && n < bound) begin
      tick();
      n++;
    end
    chk("wait_load_timeout", 32'(bus.load), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_data  = 4'd0;
    #1;
    chk("rst_level",     32'(level),         32'd0);
    chk("rst_load",      32'(bus.load),      32'd0);
    chk("rst_data",      32'(bus.data),      32'd0);
    chk("rst_expired",   32'(expired),       32'd0);
    chk("rst_underflow", 32'(underflow),     32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_ready",     32'(bus.req_ready), 32'd1);
    tick();
    tick();

    // Push 3 then 5: reload exactly at count zero, no wrap to F.
    rst           = 1'b0;
    bus.enable    = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd3;
    tick();
    chk("t1_first_push_level", 32'(level), 32'd1);
    bus.req_data = 4'd5;
    #1;
    chk("t1_idle_load", 32'(bus.load), 32'd1);
    chk("t1_idle_data", 32'(bus.data), 32'd3);
    chk("t1_idle_busy", 32'(busy),     32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("t1_count3", 32'(bus.count), 32'd3);
    chk("t1_busy",   32'(busy),      32'd1);
    chk("t1_level",  32'(level),     32'd1);
    chk("t1_noload", 32'(bus.load),  32'd0);
    for (int i = 2; i >= 0; i--) begin
      tick();
      chk("t1_count",   32'(bus.count),         32'(i));
      chk("t1_no_wrap", 32'(bus.count == 4'hF), 32'd0);
      chk("t1_load",    32'(bus.load),          32'(i == 0));
    end
    chk("t1_reload_data", 32'(bus.data), 32'd5);
    tick();
    chk("t1_count5", 32'(bus.count), 32'd5);
    chk("t1_empty",  32'(level),     32'd0);
    wait_idle(20);

    // Six back-to-back offers into an empty FIFO with loads held off.
    bus.enable = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 4'(i + 1);
      #1;
      chk("t2_ready", 32'(bus.req_ready), 32'(i < 4));
      tick();
    end
    bus.req_valid = 1'b0;
    chk("t2_level_full", 32'(level),    32'd4);
    chk("t2_head",       32'(bus.data), 32'd1);
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      wait_load(20);
      chk("t2_pop_data", 32'(bus.data), 32'(i));
      tick();
    end
    wait_idle(20);
    chk("t2_drained_level", 32'(level),    32'd0);
    chk("t2_drained_data",  32'(bus.data), 32'd0);
    tick();
    tick();

    // Single value 2: expire with empty FIFO gives underflow.
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd2;
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t3_load", 32'(bus.load), 32'd1);
    tick();
    chk("t3_count2", 32'(bus.count), 32'd2);
    tick();
    tick();
    chk("t3_count0",    32'(bus.count), 32'd0);
    chk("t3_noload",    32'(bus.load),  32'd0);
    chk("t3_exp_early", 32'(expired),   32'd0);
    tick();
    chk("t3_expired",   32'(expired),   32'd1);
    chk("t3_underflow", 32'(underflow), 32'd1);
    chk("t3_idle",      32'(busy),      32'd0);
    tick();
    chk("t3_exp_once", 32'(expired),   32'd0);
    chk("t3_uf_once",  32'(underflow), 32'd0);
    chk("t3_still_idle", 32'(busy),    32'd0);

    // Load 9, drop enable at 5; re-enabling during drain must not reload.
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd9;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("t4_count9", 32'(bus.count), 32'd9);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_count5", 32'(bus.count), 32'd5);
    bus.enable = 1'b0;
    tick();
    chk("t4_drain_busy", 32'(busy), 32'd1);
    bus.enable    = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd7;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      #1;
      chk("t4_drain_count",  32'(bus.count), 32'(i));
      chk("t4_drain_noload", 32'(bus.load),  32'd0);
      if (i > 0) tick();
    end
    tick();
    chk("t4_expired",     32'(expired),   32'd1);
    chk("t4_no_underflow", 32'(underflow), 32'd0);
    chk("t4_idle",        32'(busy),      32'd0);
    chk("t4_idle_load",   32'(bus.load),  32'd1);
    chk("t4_idle_data",   32'(bus.data),  32'd7);
    tick();
    wait_idle(20);
    tick();
    tick();

    // Reset mid-run with two values queued.
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd8;
    tick();
    bus.req_data = 4'd1;
    tick();
    bus.req_data = 4'd2;
    tick();
    bus.req_valid = 1'b0;
    for (int n = 0; n < 10 && bus.count != 4'd4; n++) tick();
    chk("t5_count4", 32'(bus.count), 32'd4);
    chk("t5_level2", 32'(level),     32'd2);
    rst = 1'b1;
    #1;
    chk("t5_rst_level", 32'(level),         32'd0);
    chk("t5_rst_load",  32'(bus.load),      32'd0);
    chk("t5_rst_busy",  32'(busy),          32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_no_load_after", 32'(bus.load), 32'd0);
      tick();
    end
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd1;
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t5_new_load", 32'(bus.load), 32'd1);
    chk("t5_new_data", 32'(bus.data), 32'd1);
    tick();
    wait_idle(20);
    tick();
    tick();

    // Push 0, 0, 1: back-to-back loads, then a 2-cycle period, then underflow.
    bus.req_valid = 1'b1;
    bus.req_data  = 4'd0;
    tick();
    #1;
    chk("t6_load_a", 32'(bus.load), 32'd1);
    chk("t6_data_a", 32'(bus.data), 32'd0);
    tick();
    bus.req_data = 4'd1;
    #1;
    chk("t6_count_b", 32'(bus.count), 32'd0);
    chk("t6_load_b",  32'(bus.load),  32'd1);
    chk("t6_data_b",  32'(bus.data),  32'd0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t6_load_c", 32'(bus.load),  32'd1);
    chk("t6_data_c", 32'(bus.data),  32'd1);
    chk("t6_exp_c",  32'(expired),   32'd1);
    chk("t6_uf_c",   32'(underflow), 32'd0);
    tick();
    chk("t6_count_d", 32'(bus.count), 32'd1);
    chk("t6_load_d",  32'(bus.load),  32'd0);
    tick();
    chk("t6_count_e", 32'(bus.count), 32'd0);
    chk("t6_load_e",  32'(bus.load),  32'd0);
    chk("t6_uf_e",    32'(underflow), 32'd0);
    tick();
    chk("t6_exp_f", 32'(expired),   32'd1);
    chk("t6_uf_f",  32'(underflow), 32'd1);
    chk("t6_idle",  32'(busy),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reload_scheduler.md
RELOAD_SCHEDULER -- requirements
Module: reload_scheduler

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of the counter data and count values.
REQ-002 Parameter DEPTH, default 4, SHALL set the reload FIFO depth and SHALL be a power of two of at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL, when high, permit loads into the downstream counter.
REQ-006 req_valid  input  1  SHALL mark req_data as a reload value offered for queuing.
REQ-007 req_data  input  WIDTH  SHALL carry the offered reload value.
REQ-008 req_ready  output  1  SHALL indicate the FIFO can accept a value this cycle.
REQ-009 count  input  WIDTH  SHALL carry the current value of the downstream loadable down counter.
REQ-010 load  output  1  SHALL drive the counter's synchronous load input.
REQ-011 data  output  WIDTH  SHALL drive the counter's load data.
REQ-012 expired  output  1  SHALL pulse for one cycle when the running count reaches zero.
REQ-013 underflow  output  1  SHALL pulse for one cycle when a count expires with enable high and the FIFO empty.
REQ-014 busy  output  1  SHALL be high in every state other than IDLE.
REQ-015 level  output  $clog2(DEPTH)+1  SHALL report the FIFO occupancy.

Function
REQ-016 A push SHALL occur when req_valid and req_ready are both high; req_ready SHALL equal not-full, registered-state based, with no dependence on a same-cycle pop.
REQ-017 A push while full SHALL be impossible by construction; the data offered SHALL be dropped and no state SHALL change.
REQ-018 A simultaneous push and pop SHALL leave level unchanged; a value pushed into an empty FIFO SHALL be poppable no earlier than the next cycle (no bypass).
REQ-019 data SHALL always equal the FIFO head entry, or zero when the FIFO is empty.
REQ-020 load SHALL be combinational, with no added latency, and SHALL pop the FIFO in the same cycle.
- IDLE: load = enable and not-empty.
- RUN: load = enable and not-empty and count==0.
- DRAIN: load = 0.
REQ-021 The FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN on load.
- RUN->DRAIN when enable is low and count!=0.
- RUN->IDLE when count==0 and no load occurs.
- RUN stays in RUN on a reload.
- DRAIN->IDLE when count==0.
- DRAIN->RUN never directly.
REQ-022 The count input SHALL be ignored in IDLE.
REQ-023 expired SHALL be registered high for the cycle after any RUN or DRAIN cycle with count==0.
REQ-024 underflow SHALL be registered high for the cycle after a RUN cycle with count==0, enable high and the FIFO empty.
REQ-025 Because reload happens in the same cycle count is zero, the counter SHALL never wrap; a loaded value N SHALL give a period of N+1 cycles, and N=0 SHALL give 1 cycle.
REQ-026 If enable is low in RUN with count==0, the block SHALL go to IDLE with no load and no underflow.

Reset
REQ-027 While rst is high the block SHALL hold state=IDLE, the FIFO empty, level=0, load=0, data=0, expired=0, underflow=0, busy=0, req_ready=1.
REQ-028 Reset asserted mid-RUN SHALL discard queued values immediately, with no load issued after deassertion until a new push.
REQ-029 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 Package reload_pkg SHALL hold the state enum type (IDLE, RUN, DRAIN) and the WIDTH and DEPTH default constants.
REQ-031 The FIFO SHALL be a sub-module reload_fifo with ports clk, rst, push, push_data, pop, head, full, empty and level; the FSM and pulse logic SHALL live in reload_scheduler.

Verification
REQ-032 The bench SHALL pair the block with the downstream loadable down counter, with WIDTH=4 and DEPTH=4.
REQ-033 Push 3 then 5 with enable=1 -> load in IDLE with data=3, count reaches 0 four cycles later, load with data=5 in that same cycle, count never shows 4'hF.
REQ-034 Push 6 values back to back into an empty FIFO -> req_ready drops after the 4th accepted value, level=4, the 5th and 6th values are not queued.
REQ-035 Queue a single value 2 -> expired and underflow both pulse once after count hits 0, then busy=0 and state is IDLE.
REQ-036 Load 9, drop enable at count=5 -> DRAIN, no load at count 0, expired pulses once and underflow stays low, return to IDLE.
REQ-037 Assert rst while count=4 with 2 entries queued -> level=0 and load=0 immediately, with no load after release until a new push.
REQ-038 Push 0 then 0 then 1 -> consecutive loads on back-to-back cycles, then a 2-cycle period, then underflow.
